multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL provide: clk  in  1  rising-edge clock.
REQ-002 SHALL provide: rst  in  1  synchronous, active-high reset; one clock, no other clock domains.
REQ-003 SHALL provide: instr_valid  in  1  fetch side offers instruction.
REQ-004 SHALL provide: instr_ready  out  1  controller accepts instruction (handshake = valid & ready).
REQ-005 SHALL provide: instruction  in  32  instruction word, sampled only on handshake.
REQ-006 SHALL provide: branch_taken  in  1  ALU compare result, sampled in EXECUTE.
REQ-007 SHALL provide: mem_done  in  1  data-memory completion, sampled in MEM.
REQ-008 SHALL provide: imm_gen_en  out  1  enable to the immediate generator.
REQ-009 SHALL provide: opcode_out  out  7  latched opcode to the immediate generator and ALU decode.
REQ-010 SHALL provide: alu_src_imm  out  1  ALU operand B = immediate.
REQ-011 SHALL provide: mem_read, mem_write, reg_write, pc_write  out  1 each  datapath strobes.
REQ-012 SHALL provide: pc_sel  out  2  0 = PC+4, 1 = PC+imm, 2 = rs1+imm (JALR).
REQ-013 SHALL provide: wb_sel  out  2  0 = ALU, 1 = memory, 2 = PC+4.
REQ-014 SHALL provide: illegal_instr  out  1  sticky trap flag.
REQ-015 SHALL provide: state  out  3  current state encoding, for debug.

Function
REQ-016 SHALL implement states IDLE=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5; encodings 6 and 7 SHALL go to TRAP.
REQ-017 SHALL assert instr_ready only in IDLE; on handshake, latch instruction[6:0] into opcode_out and move to DECODE.
REQ-018 SHALL assert imm_gen_en in DECODE, EXECUTE and MEM, and only for opcodes carrying an immediate (every recognised class except R).
REQ-019 DECODE SHALL recognise R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111 and JALR 1100111; any other opcode SHALL go to TRAP.
REQ-020 alu_src_imm SHALL be 1 in EXECUTE and MEM for I-ALU, LOAD, STORE and JALR, and 0 otherwise.
REQ-021 EXECUTE transitions SHALL be: R and I-ALU -> WB; LOAD and STORE -> MEM; JAL and JALR -> WB; BRANCH -> IDLE.
REQ-022 BRANCH in EXECUTE SHALL pulse pc_write, with pc_sel = 1 if branch_taken else 0.
REQ-023 MEM SHALL hold mem_read (LOAD) or mem_write (STORE) high every cycle until the cycle in which mem_done=1 is sampled.
REQ-024 On mem_done, LOAD SHALL go to WB; STORE SHALL pulse pc_write (pc_sel=0) and go to IDLE.
REQ-025 mem_done outside MEM SHALL be ignored.
REQ-026 WB SHALL pulse reg_write and pc_write for one cycle, then go to IDLE.
REQ-027 WB SHALL drive wb_sel = 0 for R/I-ALU, 1 for LOAD and 2 for JAL/JALR.
REQ-028 WB SHALL drive pc_sel = 1 for JAL, 2 for JALR and 0 otherwise.
REQ-029 Latency from handshake edge SHALL be: R/I/JAL/JALR = WB in cycle 3 and ready in cycle 4; BRANCH = ready in cycle 3; LOAD = WB one cycle after mem_done; STORE = ready one cycle after mem_done.
REQ-030 TRAP SHALL hold illegal_instr=1 and instr_ready=0, and deassert all strobes, until rst.
REQ-031 All outputs SHALL be registered or decoded from the registered state only; no combinational path from instr_valid to instr_ready.

Reset
REQ-032 rst SHALL force state=IDLE and opcode_out=0, and clear illegal_instr, all strobes, pc_sel, wb_sel and the watchdog.
REQ-033 In the first cycle after reset, instr_ready SHALL be 1.
REQ-034 rst asserted mid-instruction (any state, including MEM with a strobe high) SHALL abort the instruction in the same edge with no further strobes.

Configuration
REQ-035 Macro MEM_TIMEOUT_EN defined: a 4-bit watchdog SHALL count cycles in MEM, clear on entry, and on the 16th consecutive cycle without mem_done SHALL go to TRAP and set illegal_instr.
REQ-036 MEM_TIMEOUT_EN defined: mem_done in that same 16th cycle SHALL win, and the instruction completes normally.
REQ-037 MEM_TIMEOUT_EN undefined: MEM SHALL wait indefinitely and no watchdog logic SHALL exist.

Verification
REQ-038 ADDI 0x00500093 handshake at cycle 0 -> imm_gen_en=1 in cycle 1, opcode_out=0x13, WB with reg_write=1 and wb_sel=0 in cycle 3, instr_ready=1 in cycle 4.
REQ-039 BEQ 0x00208463 with branch_taken=1 -> pc_write=1 and pc_sel=1 in cycle 2, no reg_write, instr_ready=1 in cycle 3; with branch_taken=0 -> pc_sel=0.
REQ-040 LW 0x0000A103 with mem_done after 3 cycles -> mem_read high for exactly 3 cycles, then WB with wb_sel=1.
REQ-041 Opcode 0x7F -> TRAP in cycle 2, illegal_instr=1 and instr_ready=0 held for 20 cycles, cleared by rst.
REQ-042 SW in MEM with rst pulsed for 1 cycle -> mem_write=0 next cycle, state=IDLE, illegal_instr=0.
REQ-043 MEM_TIMEOUT_EN defined, SW with mem_done never asserted -> mem_write high for 16 cycles, then TRAP; undefined -> still in MEM after 100 cycles.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle instruction-sequencing FSM for a small RV32-style core.
// Sequence: IDLE -> DECODE -> EXECUTE -> (MEM) -> (WB) -> IDLE. Unknown opcodes and
// unused state encodings park the controller in TRAP until reset.
// Optional feature: define MEM_TIMEOUT_EN to add a 4-bit MEM watchdog. It traps when
// 16 consecutive MEM cycles pass without mem_done. Without the macro, MEM waits
// indefinitely and no watchdog logic is built.
module multicycle_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instruction,
   input  logic        branch_taken,
   input  logic        mem_done,
   output logic        imm_gen_en,
   output logic [6:0]  opcode_out,
   output logic        alu_src_imm,
   output logic        mem_read,
   output logic        mem_write,
   output logic        reg_write,
   output logic        pc_write,
   output logic [1:0]  pc_sel,
   output logic [1:0]  wb_sel,
   output logic        illegal_instr,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DECODE  = 3'd1,
      EXECUTE = 3'd2,
      MEM     = 3'd3,
      WB      = 3'd4,
      TRAP    = 3'd5
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   state_t     state_q, state_d;
   logic [6:0] opcode_q, opcode_d;

`ifdef MEM_TIMEOUT_EN
   logic [3:0] wdog_q, wdog_d;
`endif

   // Only the opcode field is consumed; the remaining fields go to the datapath directly.
   logic [24:0] instr_unused;
   assign instr_unused = instruction[31:7];

   logic is_r, is_i_alu, is_load, is_store, is_branch, is_jal, is_jalr;
   logic is_legal, has_imm, uses_imm_b;

   // Classify the latched opcode; every output below depends only on registered state.
   always_comb begin
      is_r       = (opcode_q == OP_R);
      is_i_alu   = (opcode_q == OP_I_ALU);
      is_load    = (opcode_q == OP_LOAD);
      is_store   = (opcode_q == OP_STORE);
      is_branch  = (opcode_q == OP_BRANCH);
      is_jal     = (opcode_q == OP_JAL);
      is_jalr    = (opcode_q == OP_JALR);
      is_legal   = is_r | is_i_alu | is_load | is_store | is_branch | is_jal | is_jalr;
      has_imm    = is_legal & ~is_r;
      uses_imm_b = is_i_alu | is_load | is_store | is_jalr;
   end

   // State, opcode latch and watchdog registers; reset aborts any instruction in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         opcode_q <= 7'd0;
`ifdef MEM_TIMEOUT_EN
         wdog_q   <= 4'd0;
`endif
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
`ifdef MEM_TIMEOUT_EN
         wdog_q   <= wdog_d;
`endif
      end
   end

   // Next-state and strobe decode; branch_taken and mem_done only matter in their own states.
   always_comb begin
      state_d     = state_q;
      opcode_d    = opcode_q;
`ifdef MEM_TIMEOUT_EN
      wdog_d      = wdog_q;
`endif
      instr_ready = 1'b0;
      imm_gen_en  = 1'b0;
      alu_src_imm = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      pc_write    = 1'b0;
      pc_sel      = 2'd0;
      wb_sel      = 2'd0;

      case (state_q)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               opcode_d = instruction[6:0];
               state_d  = DECODE;
            end
         end

         DECODE: begin
            imm_gen_en = has_imm;
            state_d    = is_legal ? EXECUTE : TRAP;
         end

         EXECUTE: begin
            imm_gen_en  = has_imm;
            alu_src_imm = uses_imm_b;
            if (is_branch) begin
               pc_write = 1'b1;
               pc_sel   = branch_taken ? 2'd1 : 2'd0;
               state_d  = IDLE;
            end else if (is_load || is_store) begin
`ifdef MEM_TIMEOUT_EN
               wdog_d  = 4'd0;
`endif
               state_d = MEM;
            end else begin
               state_d = WB;
            end
         end

         MEM: begin
            imm_gen_en  = has_imm;
            alu_src_imm = uses_imm_b;
            mem_read    = is_load;
            mem_write   = is_store;
            if (mem_done) begin
               if (is_load) begin
                  state_d = WB;
               end else begin
                  // Stores have no writeback, so the PC advances as memory completes.
                  pc_write = 1'b1;
                  pc_sel   = 2'd0;
                  state_d  = IDLE;
               end
`ifdef MEM_TIMEOUT_EN
            end else if (wdog_q == 4'hF) begin
               state_d = TRAP;
            end else begin
               wdog_d = wdog_q + 4'd1;
`endif
            end
         end

         WB: begin
            reg_write = 1'b1;
            pc_write  = 1'b1;
            if (is_load) begin
               wb_sel = 2'd1;
            end else if (is_jal || is_jalr) begin
               wb_sel = 2'd2;
            end else begin
               wb_sel = 2'd0;
            end
            if (is_jal) begin
               pc_sel = 2'd1;
            end else if (is_jalr) begin
               pc_sel = 2'd2;
            end else begin
               pc_sel = 2'd0;
            end
            state_d = IDLE;
         end

         TRAP: begin
            state_d = TRAP;
         end

         default: begin
            state_d = TRAP;
         end
      endcase
   end

   assign opcode_out    = opcode_q;
   assign illegal_instr = (state_q == TRAP);
   assign state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl.
// Each scenario queues per-cycle rows (stimulus plus expected outputs) and then
// replays them, comparing the full output vector at the falling edge.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_DEC  = 3'd1;
   localparam logic [2:0] S_EXE  = 3'd2;
   localparam logic [2:0] S_MEM  = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;
   localparam logic [2:0] S_TRAP = 3'd5;

   localparam logic [31:0] I_ADDI = 32'h00500093;
   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_JAL  = 32'h008000EF;
   localparam logic [31:0] I_JALR = 32'h000080E7;
   localparam logic [31:0] I_BEQ  = 32'h00208463;
   localparam logic [31:0] I_LW   = 32'h0000A103;
   localparam logic [31:0] I_SW   = 32'h0020A023;
   localparam logic [31:0] I_BAD  = 32'h0000007F;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic        branch_taken;
   logic        mem_done;
   logic        imm_gen_en;
   logic [6:0]  opcode_out;
   logic        alu_src_imm;
   logic        mem_read;
   logic        mem_write;
   logic        reg_write;
   logic        pc_write;
   logic [1:0]  pc_sel;
   logic [1:0]  wb_sel;
   logic        illegal_instr;
   logic [2:0]  state;

   multicycle_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instruction  (instruction),
      .branch_taken (branch_taken),
      .mem_done     (mem_done),
      .imm_gen_en   (imm_gen_en),
      .opcode_out   (opcode_out),
      .alu_src_imm  (alu_src_imm),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .reg_write    (reg_write),
      .pc_write     (pc_write),
      .pc_sel       (pc_sel),
      .wb_sel       (wb_sel),
      .illegal_instr(illegal_instr),
      .state        (state)
   );

   always #5 clk = ~clk;

   // Observed vector: {state, ready, imm_en, alu_src_imm, mem_read, mem_write,
   //                   reg_write, pc_write, pc_sel, wb_sel, illegal, opcode}
   logic [21:0] obs_vec;
   assign obs_vec = {state, instr_ready, imm_gen_en, alu_src_imm, mem_read, mem_write,
                     reg_write, pc_write, pc_sel, wb_sel, illegal_instr, opcode_out};

   typedef struct {
      string       tag;
      logic [3:0]  stim;   // {instr_valid, branch_taken, mem_done, rst}
      logic [31:0] ins;
      logic [21:0] exp;
   } row_t;

   row_t       sb[$];
   int         n_assert = 0;
   int         n_fail   = 0;
   logic [6:0] last_op  = 7'h00;

   // fl = {ready, imm_en, alu_src_imm, mem_read, mem_write, reg_write, pc_write}
   function automatic row_t mk(input string tag, input logic [3:0] stim,
                               input logic [31:0] ins, input logic [2:0] st,
                               input logic [6:0] fl, input logic [1:0] ps,
                               input logic [1:0] ws, input logic ill,
                               input logic [6:0] op);
      row_t x;
      x.tag  = tag;
      x.stim = stim;
      x.ins  = ins;
      x.exp  = {st, fl, ps, ws, ill, op};
      return x;
   endfunction

   task automatic drive(input row_t x);
      instr_valid  = x.stim[3];
      branch_taken = x.stim[2];
      mem_done     = x.stim[1];
      rst          = x.stim[0];
      instruction  = x.ins;
   endtask

   task automatic test_reset();
      row_t r;
      sb.push_back(mk("reset_idle",  4'b0000, 32'h0, S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, 7'h00));
      sb.push_back(mk("reset_idle2", 4'b0010, 32'h0, S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, 7'h00));
      while (sb.size() > 0) begin
         r = sb.pop_front();
         drive(r);
         @(negedge clk);
         n_assert++;
         if (obs_vec !== r.exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", r.tag, obs_vec, r.exp);
         end
         @(posedge clk);
         #1;
      end
      last_op = 7'h00;
   endtask

   task automatic test_alu_imm();
      row_t r;
      sb.push_back(mk("addi_hs",  4'b1000, I_ADDI, S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, last_op));
      sb.push_back(mk("addi_dec", 4'b1000, I_ADD,  S_DEC,  7'b0100000, 2'd0, 2'd0, 1'b0, 7'h13));
      sb.push_back(mk("addi_exe", 4'b0000, 32'h0,  S_EXE,  7'b0110000, 2'd0, 2'd0, 1'b0, 7'h13));
      sb.push_back(mk("addi_wb",  4'b0000, 32'h0,  S_WB,   7'b0000011, 2'd0, 2'd0, 1'b0, 7'h13));
      sb.push_back(mk("addi_rdy", 4'b0000, 32'h0,  S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, 7'h13));
      while (sb.size() > 0) begin
         r = sb.pop_front();
         drive(r);
         @(negedge clk);
         n_assert++;
         if (obs_vec !== r.exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", r.tag, obs_vec, r.exp);
         end
         @(posedge clk);
         #1;
      end
      last_op = 7'h13;
   endtask

   task automatic test_back_to_back();
      row_t r;
      sb.push_back(mk("add_hs",   4'b1000, I_ADD,  S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, last_op));
      sb.push_back(mk("add_dec",  4'b0000, 32'h0,  S_DEC,  7'b0000000, 2'd0, 2'd0, 1'b0, 7'h33));
      sb.push_back(mk("add_exe",  4'b0000, 32'h0,  S_EXE,  7'b0000000, 2'd0, 2'd0, 1'b0, 7'h33));
      sb.push_back(mk("add_wb",   4'b0000, 32'h0,  S_WB,   7'b0000011, 2'd0, 2'd0, 1'b0, 7'h33));
      sb.push_back(mk("jal_hs",   4'b1000, I_JAL,  S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, 7'h33));
      sb.push_back(mk("jal_dec",  4'b0000, 32'h0,  S_DEC,  7'b0100000, 2'd0, 2'd0, 1'b0, 7'h6F));
      sb.push_back(mk("jal_exe",  4'b0000, 32'h0,  S_EXE,  7'b0100000, 2'd0, 2'd0, 1'b0, 7'h6F));
      sb.push_back(mk("jal_wb",   4'b0000, 32'h0,  S_WB,   7'b0000011, 2'd1, 2'd2, 1'b0, 7'h6F));
      sb.push_back(mk("jalr_hs",  4'b1000, I_JALR, S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, 7'h6F));
      sb.push_back(mk("jalr_dec", 4'b0000, 32'h0,  S_DEC,  7'b0100000, 2'd0, 2'd0, 1'b0, 7'h67));
      sb.push_back(mk("jalr_exe", 4'b0000, 32'h0,  S_EXE,  7'b0110000, 2'd0, 2'd0, 1'b0, 7'h67));
      sb.push_back(mk("jalr_wb",  4'b0000, 32'h0,  S_WB,   7'b0000011, 2'd2, 2'd2, 1'b0, 7'h67));
      sb.push_back(mk("b2b_rdy",  4'b0000, 32'h0,  S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, 7'h67));
      while (sb.size() > 0) begin
         r = sb.pop_front();
         drive(r);
         @(negedge clk);
         n_assert++;
         if (obs_vec !== r.exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", r.tag, obs_vec, r.exp);
         end
         @(posedge clk);
         #1;
      end
      last_op = 7'h67;
   endtask

   task automatic test_branch();
      row_t r;
      sb.push_back(mk("beq_hs",    4'b1000, I_BEQ, S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, last_op));
      sb.push_back(mk("beq_dec",   4'b0000, 32'h0, S_DEC,  7'b0100000, 2'd0, 2'd0, 1'b0, 7'h63));
      sb.push_back(mk("beq_t_exe", 4'b0100, 32'h0, S_EXE,  7'b0100001, 2'd1, 2'd0, 1'b0, 7'h63));
      sb.push_back(mk("beq_t_rdy", 4'b1000, I_BEQ, S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, 7'h63));
      sb.push_back(mk("beq_n_dec", 4'b0100, 32'h0, S_DEC,  7'b0100000, 2'd0, 2'd0, 1'b0, 7'h63));
      sb.push_back(mk("beq_n_exe", 4'b0000, 32'h0, S_EXE,  7'b0100001, 2'd0, 2'd0, 1'b0, 7'h63));
      sb.push_back(mk("beq_n_rdy", 4'b0000, 32'h0, S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, 7'h63));
      while (sb.size() > 0) begin
         r = sb.pop_front();
         drive(r);
         @(negedge clk);
         n_assert++;
         if (obs_vec !== r.exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", r.tag, obs_vec, r.exp);
         end
         @(posedge clk);
         #1;
      end
      last_op = 7'h63;
   endtask

   task automatic test_load();
      row_t r;
      // mem_done outside MEM must have no effect
      sb.push_back(mk("lw_hs",   4'b1010, I_LW,  S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, last_op));
      sb.push_back(mk("lw_dec",  4'b0010, 32'h0, S_DEC,  7'b0100000, 2'd0, 2'd0, 1'b0, 7'h03));
      sb.push_back(mk("lw_exe",  4'b0010, 32'h0, S_EXE,  7'b0110000, 2'd0, 2'd0, 1'b0, 7'h03));
      sb.push_back(mk("lw_mem1", 4'b0000, 32'h0, S_MEM,  7'b0111000, 2'd0, 2'd0, 1'b0, 7'h03));
      sb.push_back(mk("lw_mem2", 4'b0000, 32'h0, S_MEM,  7'b0111000, 2'd0, 2'd0, 1'b0, 7'h03));
      sb.push_back(mk("lw_mem3", 4'b0010, 32'h0, S_MEM,  7'b0111000, 2'd0, 2'd0, 1'b0, 7'h03));
      sb.push_back(mk("lw_wb",   4'b0010, 32'h0, S_WB,   7'b0000011, 2'd0, 2'd1, 1'b0, 7'h03));
      sb.push_back(mk("lw_rdy",  4'b0000, 32'h0, S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, 7'h03));
      while (sb.size() > 0) begin
         r = sb.pop_front();
         drive(r);
         @(negedge clk);
         n_assert++;
         if (obs_vec !== r.exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", r.tag, obs_vec, r.exp);
         end
         @(posedge clk);
         #1;
      end
      last_op = 7'h03;
   endtask

   task automatic test_store();
      row_t r;
      sb.push_back(mk("sw_hs",   4'b1000, I_SW,  S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, last_op));
      sb.push_back(mk("sw_dec",  4'b0000, 32'h0, S_DEC,  7'b0100000, 2'd0, 2'd0, 1'b0, 7'h23));
      sb.push_back(mk("sw_exe",  4'b0000, 32'h0, S_EXE,  7'b0110000, 2'd0, 2'd0, 1'b0, 7'h23));
      sb.push_back(mk("sw_mem1", 4'b0000, 32'h0, S_MEM,  7'b0110100, 2'd0, 2'd0, 1'b0, 7'h23));
      sb.push_back(mk("sw_done", 4'b0010, 32'h0, S_MEM,  7'b0110101, 2'd0, 2'd0, 1'b0, 7'h23));
      sb.push_back(mk("sw_rdy",  4'b0000, 32'h0, S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, 7'h23));
      while (sb.size() > 0) begin
         r = sb.pop_front();
         drive(r);
         @(negedge clk);
         n_assert++;
         if (obs_vec !== r.exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", r.tag, obs_vec, r.exp);
         end
         @(posedge clk);
         #1;
      end
      last_op = 7'h23;
   endtask

   task automatic test_reset_mid();
      row_t r;
      sb.push_back(mk("rm_hs",    4'b1000, I_SW,  S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, last_op));
      sb.push_back(mk("rm_dec",   4'b0000, 32'h0, S_DEC,  7'b0100000, 2'd0, 2'd0, 1'b0, 7'h23));
      sb.push_back(mk("rm_exe",   4'b0000, 32'h0, S_EXE,  7'b0110000, 2'd0, 2'd0, 1'b0, 7'h23));
      sb.push_back(mk("rm_mem",   4'b0001, 32'h0, S_MEM,  7'b0110100, 2'd0, 2'd0, 1'b0, 7'h23));
      sb.push_back(mk("rm_idle",  4'b0000, 32'h0, S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, 7'h00));
      sb.push_back(mk("rm_idle2", 4'b0010, 32'h0, S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, 7'h00));
      while (sb.size() > 0) begin
         r = sb.pop_front();
         drive(r);
         @(negedge clk);
         n_assert++;
         if (obs_vec !== r.exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", r.tag, obs_vec, r.exp);
         end
         @(posedge clk);
         #1;
      end
      last_op = 7'h00;
   endtask

   task automatic test_illegal();
      row_t r;
      sb.push_back(mk("bad_hs",  4'b1000, I_BAD, S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, last_op));
      sb.push_back(mk("bad_dec", 4'b0000, 32'h0, S_DEC,  7'b0000000, 2'd0, 2'd0, 1'b0, 7'h7F));
      for (int i = 0; i < 20; i++)
         sb.push_back(mk("bad_trap", 4'b1110, I_ADDI, S_TRAP, 7'b0000000, 2'd0, 2'd0, 1'b1, 7'h7F));
      sb.push_back(mk("bad_rst", 4'b1001, I_ADDI, S_TRAP, 7'b0000000, 2'd0, 2'd0, 1'b1, 7'h7F));
      sb.push_back(mk("bad_clr", 4'b0000, 32'h0,  S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, 7'h00));
      while (sb.size() > 0) begin
         r = sb.pop_front();
         drive(r);
         @(negedge clk);
         n_assert++;
         if (obs_vec !== r.exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", r.tag, obs_vec, r.exp);
         end
         @(posedge clk);
         #1;
      end
      last_op = 7'h00;
   endtask

   task automatic test_mem_wait();
      row_t r;
`ifdef MEM_TIMEOUT_EN
      // mem_done on the 16th MEM cycle beats the watchdog
      sb.push_back(mk("tw_hs",  4'b1000, I_SW,  S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, last_op));
      sb.push_back(mk("tw_dec", 4'b0000, 32'h0, S_DEC,  7'b0100000, 2'd0, 2'd0, 1'b0, 7'h23));
      sb.push_back(mk("tw_exe", 4'b0000, 32'h0, S_EXE,  7'b0110000, 2'd0, 2'd0, 1'b0, 7'h23));
      for (int i = 0; i < 15; i++)
         sb.push_back(mk("tw_mem", 4'b0000, 32'h0, S_MEM, 7'b0110100, 2'd0, 2'd0, 1'b0, 7'h23));
      sb.push_back(mk("tw_mem16", 4'b0010, 32'h0, S_MEM,  7'b0110101, 2'd0, 2'd0, 1'b0, 7'h23));
      sb.push_back(mk("tw_rdy",   4'b0000, 32'h0, S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, 7'h23));
      // A fresh store must get a full 16 cycles again before trapping
      sb.push_back(mk("to_hs",  4'b1000, I_SW,  S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, 7'h23));
      sb.push_back(mk("to_dec", 4'b0000, 32'h0, S_DEC,  7'b0100000, 2'd0, 2'd0, 1'b0, 7'h23));
      sb.push_back(mk("to_exe", 4'b0000, 32'h0, S_EXE,  7'b0110000, 2'd0, 2'd0, 1'b0, 7'h23));
      for (int i = 0; i < 16; i++)
         sb.push_back(mk("to_mem", 4'b0000, 32'h0, S_MEM, 7'b0110100, 2'd0, 2'd0, 1'b0, 7'h23));
      sb.push_back(mk("to_trap", 4'b0000, 32'h0, S_TRAP, 7'b0000000, 2'd0, 2'd0, 1'b1, 7'h23));
      sb.push_back(mk("to_rst",  4'b0001, 32'h0, S_TRAP, 7'b0000000, 2'd0, 2'd0, 1'b1, 7'h23));
      sb.push_back(mk("to_clr",  4'b0000, 32'h0, S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, 7'h00));
`else
      sb.push_back(mk("nt_hs",  4'b1000, I_SW,  S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, last_op));
      sb.push_back(mk("nt_dec", 4'b0000, 32'h0, S_DEC,  7'b0100000, 2'd0, 2'd0, 1'b0, 7'h23));
      sb.push_back(mk("nt_exe", 4'b0000, 32'h0, S_EXE,  7'b0110000, 2'd0, 2'd0, 1'b0, 7'h23));
      for (int i = 0; i < 100; i++)
         sb.push_back(mk("nt_mem", 4'b0000, 32'h0, S_MEM, 7'b0110100, 2'd0, 2'd0, 1'b0, 7'h23));
      sb.push_back(mk("nt_rst", 4'b0001, 32'h0, S_MEM,  7'b0110100, 2'd0, 2'd0, 1'b0, 7'h23));
      sb.push_back(mk("nt_clr", 4'b0000, 32'h0, S_IDLE, 7'b1000000, 2'd0, 2'd0, 1'b0, 7'h00));
`endif
      while (sb.size() > 0) begin
         r = sb.pop_front();
         drive(r);
         @(negedge clk);
         n_assert++;
         if (obs_vec !== r.exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", r.tag, obs_vec, r.exp);
         end
         @(posedge clk);
         #1;
      end
      last_op = 7'h00;
   endtask

   initial begin
      #200000;
      $display("FAIL sim_timeout: got running want finished");
      $fatal(1);
   end

   initial begin
      rst          = 1'b1;
      instr_valid  = 1'b0;
      instruction  = 32'h0;
      branch_taken = 1'b0;
      mem_done     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_alu_imm();
      test_back_to_back();
      test_branch();
      test_load();
      test_store();
      test_reset_mid();
      test_illegal();
      test_mem_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
